// File: rtl/riscv_exc_controller_pkg.sv
// Shared cause codes, state encoding and helpers for the ID-stage exception sequencer.
package riscv_exc_controller_pkg;

  localparam logic [5:0] EXC_CAUSE_ILLEGAL = 6'h02;
  localparam logic [5:0] EXC_CAUSE_ECALL   = 6'h0B;
  localparam int         EXC_IRQ_FLAG      = 5;

  typedef enum logic [1:0] {
    EXC_IDLE,
    EXC_REQ,
    EXC_FLUSH
  } exc_state_t;

  // IRQ causes carry the interrupt flag in bit 5 and the line number below it
  function automatic logic [5:0] irq_cause(input logic [4:0] line);
    return {1'b1, line};
  endfunction

endpackage

// File: rtl/riscv_exc_controller_irq_prio_enc.sv
// Fixed-priority encoder over the interrupt lines; line 0 has the highest priority.
module riscv_irq_prio_enc #(
  parameter int N_IRQ = 32
) (
  input  logic [N_IRQ-1:0] irq,
  output logic             irq_valid,
  output logic [4:0]       irq_idx
);

  // Scan from the top down so the lowest asserted line is the last (winning) write
  always_comb begin
    irq_valid = 1'b0;
    irq_idx   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq[i]) begin
        irq_valid = 1'b1;
        irq_idx   = i[4:0];
      end
    end
  end

endmodule

// File: rtl/riscv_exc_controller.sv
// Exception/interrupt sequencer: arbitrates traps, handshakes with the controller and
// drives the CSR save/restore strobes.
module riscv_exc_controller
  import riscv_exc_controller_pkg::*;
#(
  parameter int N_IRQ = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             irq_enable_i,
  input  logic             instr_valid_i,
  input  logic             illegal_insn_i,
  input  logic             ecall_insn_i,
  input  logic             mret_insn_i,
  input  logic             ctrl_ack_i,
  output logic             req_o,
  output logic [5:0]       cause_o,
  output logic             irq_pending_o,
  output logic             save_if_o,
  output logic             save_id_o,
  output logic             save_cause_o,
  output logic             restore_o
);

  exc_state_t state_q, state_d;
  logic [5:0] cause_q, cause_d;
  logic       restore_q, restore_d;
  logic       irq_valid;
  logic [4:0] irq_idx;

  riscv_irq_prio_enc #(
    .N_IRQ(N_IRQ)
  ) u_prio_enc (
    .irq      (irq_i),
    .irq_valid(irq_valid),
    .irq_idx  (irq_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EXC_IDLE;
      cause_q   <= '0;
      restore_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      restore_q <= restore_d;
    end
  end

  // A pending IRQ is deliberately skipped on an mret cycle: IE comes back next cycle
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    restore_d    = 1'b0;
    save_if_o    = 1'b0;
    save_id_o    = 1'b0;
    save_cause_o = 1'b0;
    unique case (state_q)
      EXC_IDLE: begin
        if (instr_valid_i && illegal_insn_i) begin
          cause_d = EXC_CAUSE_ILLEGAL;
          state_d = EXC_REQ;
        end else if (instr_valid_i && ecall_insn_i) begin
          cause_d = EXC_CAUSE_ECALL;
          state_d = EXC_REQ;
        end else if (instr_valid_i && mret_insn_i) begin
          restore_d = 1'b1;
        end else if (irq_enable_i && irq_valid) begin
          cause_d = irq_cause(irq_idx);
          state_d = EXC_REQ;
        end
      end
      EXC_REQ: begin
        if (ctrl_ack_i && !rst) begin
          save_cause_o = 1'b1;
          save_if_o    = cause_q[EXC_IRQ_FLAG];
          save_id_o    = !cause_q[EXC_IRQ_FLAG];
          state_d      = EXC_FLUSH;
        end
      end
      EXC_FLUSH: begin
        state_d = EXC_IDLE;
      end
      default: begin
        state_d = EXC_IDLE;
      end
    endcase
  end

  assign req_o         = (state_q == EXC_REQ);
  assign cause_o       = req_o ? cause_q : 6'h00;
  assign restore_o     = restore_q;
  assign irq_pending_o = (|irq_i) & irq_enable_i;

endmodule

// File: tb/tb_riscv_exc_controller.sv
// Directed self-checking bench for the exception sequencer.
module tb_riscv_exc_controller;

  logic        clk;
  logic        rst;
  logic [31:0] irq_i;
  logic        irq_enable_i;
  logic        instr_valid_i;
  logic        illegal_insn_i;
  logic        ecall_insn_i;
  logic        mret_insn_i;
  logic        ctrl_ack_i;
  logic        req_o;
  logic [5:0]  cause_o;
  logic        irq_pending_o;
  logic        save_if_o;
  logic        save_id_o;
  logic        save_cause_o;
  logic        restore_o;

  int tests_run;
  int tests_failed;

  riscv_exc_controller #(
    .N_IRQ(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_i         (irq_i),
    .irq_enable_i  (irq_enable_i),
    .instr_valid_i (instr_valid_i),
    .illegal_insn_i(illegal_insn_i),
    .ecall_insn_i  (ecall_insn_i),
    .mret_insn_i   (mret_insn_i),
    .ctrl_ack_i    (ctrl_ack_i),
    .req_o         (req_o),
    .cause_o       (cause_o),
    .irq_pending_o (irq_pending_o),
    .save_if_o     (save_if_o),
    .save_id_o     (save_id_o),
    .save_cause_o  (save_cause_o),
    .restore_o     (restore_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    irq_i          = '0;
    irq_enable_i   = 1'b0;
    instr_valid_i  = 1'b0;
    illegal_insn_i = 1'b0;
    ecall_insn_i   = 1'b0;
    mret_insn_i    = 1'b0;
    ctrl_ack_i     = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    #1;
    tests_run++;
    if ({req_o, cause_o, save_if_o, save_id_o, save_cause_o, restore_o, irq_pending_o} !== 12'h000) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got req=%b cause=%h sif=%b sid=%b sc=%b rst=%b pend=%b want all 0",
               req_o, cause_o, save_if_o, save_id_o, save_cause_o, restore_o, irq_pending_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    instr_valid_i  = 1'b1;
    illegal_insn_i = 1'b1;
    #1;
    tests_run++;
    if (req_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL illegal_req_before got %b want 0", req_o);
    end
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (req_o !== 1'b1 || cause_o !== 6'h02 || save_id_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL illegal_req1 got req=%b cause=%h sid=%b want 1 02 0", req_o, cause_o, save_id_o);
    end
    tick();
    tests_run++;
    if (req_o !== 1'b1 || cause_o !== 6'h02) begin
      tests_failed++;
      $display("[TB] FAIL illegal_req2 got req=%b cause=%h want 1 02", req_o, cause_o);
    end
    tick();
    ctrl_ack_i = 1'b1;
    #1;
    tests_run++;
    if (req_o !== 1'b1 || save_id_o !== 1'b1 || save_cause_o !== 1'b1 || save_if_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL illegal_ack got req=%b sid=%b sc=%b sif=%b want 1 1 1 0",
               req_o, save_id_o, save_cause_o, save_if_o);
    end
    tick();
    ctrl_ack_i = 1'b0;
    #1;
    tests_run++;
    if (req_o !== 1'b0 || save_cause_o !== 1'b0 || save_id_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL illegal_flush got req=%b sc=%b sid=%b want 0 0 0", req_o, save_cause_o, save_id_o);
    end
    tick();
  endtask

  task automatic test_ecall();
    instr_valid_i  = 1'b0;
    illegal_insn_i = 1'b1;
    ecall_insn_i   = 1'b1;
    tick();
    tests_run++;
    if (req_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL unqualified_sync got req=%b want 0", req_o);
    end
    illegal_insn_i = 1'b0;
    instr_valid_i  = 1'b1;
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (req_o !== 1'b1 || cause_o !== 6'h0B) begin
      tests_failed++;
      $display("[TB] FAIL ecall_cause got req=%b cause=%h want 1 0b", req_o, cause_o);
    end
    ctrl_ack_i = 1'b1;
    #1;
    tests_run++;
    if (save_id_o !== 1'b1 || save_if_o !== 1'b0 || save_cause_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ecall_ack got sid=%b sif=%b sc=%b want 1 0 1", save_id_o, save_if_o, save_cause_o);
    end
    tick();
    ctrl_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_irq();
    irq_i        = 32'h0000_0050;
    irq_enable_i = 1'b1;
    #1;
    tests_run++;
    if (irq_pending_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL irq_pending_en got %b want 1", irq_pending_o);
    end
    tick();
    tests_run++;
    if (req_o !== 1'b1 || cause_o !== 6'h24) begin
      tests_failed++;
      $display("[TB] FAIL irq_cause got req=%b cause=%h want 1 24", req_o, cause_o);
    end
    ctrl_ack_i = 1'b1;
    #1;
    tests_run++;
    if (save_if_o !== 1'b1 || save_id_o !== 1'b0 || save_cause_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL irq_ack got sif=%b sid=%b sc=%b want 1 0 1", save_if_o, save_id_o, save_cause_o);
    end
    tick();
    ctrl_ack_i   = 1'b0;
    irq_enable_i = 1'b0;
    tick();
    #1;
    tests_run++;
    if (irq_pending_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL irq_pending_dis got %b want 0", irq_pending_o);
    end
    tick();
    tick();
    tests_run++;
    if (req_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL irq_masked_req got %b want 0", req_o);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_priority();
    irq_i          = 32'h0000_0001;
    irq_enable_i   = 1'b1;
    instr_valid_i  = 1'b1;
    illegal_insn_i = 1'b1;
    ecall_insn_i   = 1'b1;
    tick();
    instr_valid_i  = 1'b0;
    illegal_insn_i = 1'b0;
    ecall_insn_i   = 1'b0;
    #1;
    tests_run++;
    if (req_o !== 1'b1 || cause_o !== 6'h02) begin
      tests_failed++;
      $display("[TB] FAIL prio_cause got req=%b cause=%h want 1 02", req_o, cause_o);
    end
    ctrl_ack_i = 1'b1;
    tick();
    ctrl_ack_i = 1'b0;
    #1;
    tests_run++;
    if (req_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL prio_flush_no_arb got req=%b want 0", req_o);
    end
    tick();
    tests_run++;
    if (req_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL prio_idle_after_flush got req=%b want 0", req_o);
    end
    tick();
    tests_run++;
    if (req_o !== 1'b1 || cause_o !== 6'h20) begin
      tests_failed++;
      $display("[TB] FAIL prio_irq0 got req=%b cause=%h want 1 20", req_o, cause_o);
    end
    clear_inputs();
    ctrl_ack_i = 1'b1;
    tick();
    ctrl_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_mret();
    irq_i         = 32'h0000_0008;
    irq_enable_i  = 1'b1;
    instr_valid_i = 1'b1;
    mret_insn_i   = 1'b1;
    #1;
    tests_run++;
    if (req_o !== 1'b0 || restore_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mret_before got req=%b restore=%b want 0 0", req_o, restore_o);
    end
    tick();
    instr_valid_i = 1'b0;
    mret_insn_i   = 1'b0;
    #1;
    tests_run++;
    if (restore_o !== 1'b1 || req_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mret_restore got restore=%b req=%b want 1 0", restore_o, req_o);
    end
    tick();
    tests_run++;
    if (restore_o !== 1'b0 || req_o !== 1'b1 || cause_o !== 6'h23) begin
      tests_failed++;
      $display("[TB] FAIL mret_then_irq got restore=%b req=%b cause=%h want 0 1 23", restore_o, req_o, cause_o);
    end
    clear_inputs();
    ctrl_ack_i = 1'b1;
    tick();
    ctrl_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_irq_drop();
    irq_i        = 32'h0000_0002;
    irq_enable_i = 1'b1;
    tick();
    irq_i = '0;
    #1;
    tests_run++;
    if (req_o !== 1'b1 || cause_o !== 6'h21 || irq_pending_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drop_req got req=%b cause=%h pend=%b want 1 21 0", req_o, cause_o, irq_pending_o);
    end
    tick();
    tests_run++;
    if (req_o !== 1'b1 || cause_o !== 6'h21) begin
      tests_failed++;
      $display("[TB] FAIL drop_hold got req=%b cause=%h want 1 21", req_o, cause_o);
    end
    ctrl_ack_i = 1'b1;
    #1;
    tests_run++;
    if (save_if_o !== 1'b1 || save_cause_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL drop_ack got sif=%b sc=%b want 1 1", save_if_o, save_cause_o);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_abort();
    instr_valid_i  = 1'b1;
    illegal_insn_i = 1'b1;
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (req_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_req got %b want 1", req_o);
    end
    rst        = 1'b1;
    ctrl_ack_i = 1'b1;
    #1;
    tests_run++;
    if (save_if_o !== 1'b0 || save_id_o !== 1'b0 || save_cause_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_strobes got sif=%b sid=%b sc=%b want 0 0 0", save_if_o, save_id_o, save_cause_o);
    end
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_o !== 1'b0 || cause_o !== 6'h00 || save_cause_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_idle got req=%b cause=%h sc=%b want 0 00 0", req_o, cause_o, save_cause_o);
    end
    tick();
    tests_run++;
    if (req_o !== 1'b0 || save_cause_o !== 1'b0 || save_id_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_ack_ignored got req=%b sc=%b sid=%b want 0 0 0", req_o, save_cause_o, save_id_o);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    clear_inputs();
    test_reset();
    test_illegal();
    test_ecall();
    test_irq();
    test_priority();
    test_mret();
    test_irq_drop();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
